// File: rtl/vga_dither.sv
// 4x4 ordered (Bayer) dither from IN_W to OUT_W bits per channel, with the
// screen position recovered from the DE/VSYNC stream and syncs kept aligned.
module vga_dither #(
  parameter int unsigned IN_W      = 6,
  parameter int unsigned OUT_W     = 4,
  parameter bit          VSYNC_POL = 1'b0,
  parameter bit          DITHER_EN = 1'b1
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out
);

  localparam int unsigned FRAC_W = IN_W - OUT_W;
  localparam int unsigned SHIFT  = 4 - FRAC_W;

  // Screen position tracking
  logic [1:0] col;
  logic [1:0] row;
  logic       de_prev;
  logic       vs_prev;

  logic       de_rise_c;
  logic       de_fall_c;
  logic       vs_edge_c;
  logic [1:0] col_c;
  logic [1:0] row_c;
  logic [3:0] thr_c;

  // Stage 1 registers
  logic [IN_W-1:0] r_s1;
  logic [IN_W-1:0] g_s1;
  logic [IN_W-1:0] b_s1;
  logic [3:0]      thr_s1;
  logic            hs_s1;
  logic            vs_s1;
  logic            de_s1;

  // Edge detection and the position used by the pixel on this cycle
  always_comb begin
    de_rise_c = de_in && !de_prev;
    de_fall_c = !de_in && de_prev;
    vs_edge_c = (vsync_in == VSYNC_POL) && (vs_prev != VSYNC_POL);
    col_c     = de_rise_c ? 2'd0 : col;
    row_c     = vs_edge_c ? 2'd0 : row;
  end

  // Bayer threshold matrix, row-major
  always_comb begin
    thr_c = 4'd0;
    case ({row_c, col_c})
      4'h0: thr_c = 4'd0;
      4'h1: thr_c = 4'd8;
      4'h2: thr_c = 4'd2;
      4'h3: thr_c = 4'd10;
      4'h4: thr_c = 4'd12;
      4'h5: thr_c = 4'd4;
      4'h6: thr_c = 4'd14;
      4'h7: thr_c = 4'd6;
      4'h8: thr_c = 4'd3;
      4'h9: thr_c = 4'd11;
      4'hA: thr_c = 4'd1;
      4'hB: thr_c = 4'd9;
      4'hC: thr_c = 4'd15;
      4'hD: thr_c = 4'd7;
      4'hE: thr_c = 4'd13;
      4'hF: thr_c = 4'd5;
      default: thr_c = 4'd0;
    endcase
  end

  // Column/row counters; a vsync edge overrides an end-of-line increment
  always_ff @(posedge aclk) begin
    if (reset) begin
      col     <= 2'd0;
      row     <= 2'd0;
      de_prev <= 1'b0;
      vs_prev <= ~VSYNC_POL;
    end else begin
      de_prev <= de_in;
      vs_prev <= vsync_in;
      if (de_in) begin
        col <= col_c + 2'd1;
      end
      if (vs_edge_c) begin
        row <= 2'd0;
      end else if (de_fall_c) begin
        row <= row + 2'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_s1   <= '0;
      g_s1   <= '0;
      b_s1   <= '0;
      thr_s1 <= 4'd0;
      hs_s1  <= 1'b0;
      vs_s1  <= ~VSYNC_POL;
      de_s1  <= 1'b0;
    end else begin
      r_s1   <= r_in;
      g_s1   <= g_in;
      b_s1   <= b_in;
      thr_s1 <= thr_c;
      hs_s1  <= hsync_in;
      vs_s1  <= vsync_in;
      de_s1  <= de_in;
    end
  end

  // Round up by one LSB when the scaled fraction beats the threshold; never wrap
  function automatic logic [OUT_W-1:0] dither_px(input logic [IN_W-1:0] px,
                                                 input logic [3:0]      thr);
    logic [OUT_W-1:0]  hi;
    logic [FRAC_W-1:0] frac;
    logic [3:0]        scaled;
    logic              inc;
    hi     = px[IN_W-1:FRAC_W];
    frac   = px[FRAC_W-1:0];
    scaled = 4'(frac) << SHIFT;
    inc    = DITHER_EN && (scaled > thr);
    if (&hi) begin
      dither_px = hi;
    end else begin
      dither_px = hi + OUT_W'(inc);
    end
  endfunction

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= ~VSYNC_POL;
      de_out    <= 1'b0;
    end else begin
      r_out     <= de_s1 ? dither_px(r_s1, thr_s1) : '0;
      g_out     <= de_s1 ? dither_px(g_s1, thr_s1) : '0;
      b_out     <= de_s1 ? dither_px(b_s1, thr_s1) : '0;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      de_out    <= de_s1;
    end
  end

endmodule
